// File: rtl/dmem_sb_pkg.sv
// Shared types and helpers for the dmem store buffer.
// Entry layout and pointer arithmetic used by the top and forwarding logic.
package dmem_sb_pkg;

  localparam int DWIDTH   = 4;
  localparam int AWIDTH   = 4;
  localparam int SB_DEPTH = 4;

  typedef struct packed {
    logic [AWIDTH-1:0] adr;
    logic [DWIDTH-1:0] data;
  } sb_entry_t;

  function automatic int ptr_inc(
    input int p,
    input int depth
  );
    return (p + 1) % depth;
  endfunction

endpackage

// File: rtl/dmem_sb_if.sv
// Data-memory side bus of the store buffer.
// master = store buffer, slave = dmem.
interface dmem_sb_if;
  import dmem_sb_pkg::*;

  logic              mem_ready;
  logic              mem_we;
  logic [AWIDTH-1:0] mem_wadr;
  logic [DWIDTH-1:0] mem_wd;
  logic [AWIDTH-1:0] mem_radr;
  logic [DWIDTH-1:0] mem_rd;

  modport master (
    input  mem_ready,
    input  mem_rd,
    output mem_we,
    output mem_wadr,
    output mem_wd,
    output mem_radr
  );

  modport slave (
    output mem_ready,
    output mem_rd,
    input  mem_we,
    input  mem_wadr,
    input  mem_wd,
    input  mem_radr
  );

endinterface

// File: rtl/dmem_sb_fwd_match.sv
// Youngest-match load forwarding over the valid store buffer entries.
// Later (younger) matches override earlier ones in the scan.
module sb_fwd_match
  import dmem_sb_pkg::*;
#(
  parameter  int DEPTH = SB_DEPTH,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  sb_entry_t         ents [DEPTH],
  input  logic [PW-1:0]     head,
  input  logic [CW-1:0]     count,
  input  logic [AWIDTH-1:0] cpu_adr,
  output logic              hit,
  output logic [DWIDTH-1:0] hit_data
);

  logic [PW-1:0] idx;

  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (i < int'(count) &&
          ents[idx].adr == cpu_adr) begin
        hit      = 1'b1;
        hit_data = ents[idx].data;
      end
    end
  end

endmodule

// File: rtl/dmem_store_buffer.sv
// Posted-write store buffer between the cpu data port and dmem.
// Stores queue in order and drain one per cycle; loads forward from it.
module dmem_store_buffer
  import dmem_sb_pkg::*;
#(
  parameter  int DEPTH = SB_DEPTH,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_we,
  input  logic [AWIDTH-1:0] cpu_adr,
  input  logic [DWIDTH-1:0] cpu_wd,
  output logic [DWIDTH-1:0] cpu_rd,
  output logic              stall,
  dmem_sb_if.master         mem,
  output logic              empty,
  output logic [CW-1:0]     count
);

  sb_entry_t         ents [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     cnt;
  logic              full;
  logic              push;
  logic              pop;
  logic              hit;
  logic [DWIDTH-1:0] hit_data;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
  assign push  = cpu_we & ~full;
  assign pop   = ~empty & mem.mem_ready;
  assign stall = cpu_we & full;

  assign mem.mem_we   = ~empty;
  assign mem.mem_wadr = ents[head].adr;
  assign mem.mem_wd   = ents[head].data;
  assign mem.mem_radr = cpu_adr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= PW'(ptr_inc(int'(tail), DEPTH));
      if (pop)  head <= PW'(ptr_inc(int'(head), DEPTH));
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry contents need no reset; validity comes from head/count.
  always_ff @(posedge clk) begin
    if (push) ents[tail] <= '{adr: cpu_adr, data: cpu_wd};
  end

  sb_fwd_match #(.DEPTH(DEPTH)) u_fwd (
    .ents     (ents),
    .head     (head),
    .count    (cnt),
    .cpu_adr  (cpu_adr),
    .hit      (hit),
    .hit_data (hit_data)
  );

  assign cpu_rd = hit ? hit_data : mem.mem_rd;

  a_cnt_max: assert property (
    @(posedge clk) disable iff (reset)
    cnt <= CW'(DEPTH));
  a_we_nonempty: assert property (
    @(posedge clk) disable iff (reset)
    mem.mem_we |-> !empty);
  a_stall_we: assert property (
    @(posedge clk) disable iff (reset)
    stall |-> cpu_we);

endmodule
